// File: rtl/majority_gate_bist.sv
// Self-test engine for an N-input majority gate.
// It drives every N-bit vector onto X and works out the expected majority
// by shifting the vector out one bit at a time and counting the ones.
// It compares the gate output Y with that value and keeps an error count,
// the first failing vector and a pass/fail verdict for the whole sweep.
module majority_gate_bist #(
   parameter int N     = 8,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N-1:0]     X,
   input  logic             Y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_seen,
   output logic [N-1:0]     first_fail
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_COUNT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [N-1:0]     r_vec;
   logic [N-1:0]     r_sh;
   logic [N-1:0]     r_first;
   logic [CW-1:0]    r_ones;
   logic [CW-1:0]    r_bitcnt;
   logic [ERR_W-1:0] r_err;
   logic             r_fail_seen;

   logic [CW:0]      w_twice_ones;
   logic             w_exp;
   logic             w_mismatch;
   logic             w_last_bit;
   logic             w_last_vec;
   logic             w_accept;

   // A tie on even N gives exp=0, so the comparison must be strictly greater.
   assign w_twice_ones = {r_ones, 1'b0};
   assign w_exp        = (w_twice_ones > (CW + 1)'(N));
   assign w_mismatch   = (Y != w_exp);
   assign w_last_bit   = (r_bitcnt == CW'(N - 1));
   assign w_last_vec   = (r_vec == '1);

   assign X          = r_vec;
   assign err_count  = r_err;
   assign fail_seen  = r_fail_seen;
   assign first_fail = r_first;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and status outputs. start is only accepted in IDLE or DONE.
   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
      w_accept = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_APPLY;
            end
         end
         S_APPLY: begin
            busy   = 1'b1;
            w_next = S_COUNT;
         end
         S_COUNT: begin
            busy = 1'b1;
            if (w_last_bit) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            busy   = 1'b1;
            w_next = w_last_vec ? S_DONE : S_APPLY;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_APPLY;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // pass is only meaningful while done is high; it drops with done on restart.
   assign pass = done && (r_err == '0);

   // Vector, serial popcount and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec       <= '0;
         r_sh        <= '0;
         r_ones      <= '0;
         r_bitcnt    <= '0;
         r_err       <= '0;
         r_fail_seen <= 1'b0;
         r_first     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_vec       <= '0;
                  r_err       <= '0;
                  r_fail_seen <= 1'b0;
                  r_first     <= '0;
               end
            end
            S_APPLY: begin
               r_sh     <= r_vec;
               r_ones   <= '0;
               r_bitcnt <= '0;
            end
            S_COUNT: begin
               r_ones   <= r_ones + CW'(r_sh[0]);
               r_sh     <= r_sh >> 1;
               r_bitcnt <= r_bitcnt + CW'(1);
            end
            S_CHECK: begin
               if (w_mismatch) begin
                  if (r_err != '1) begin
                     r_err <= r_err + ERR_W'(1);
                  end
                  if (!r_fail_seen) begin
                     r_fail_seen <= 1'b1;
                     r_first     <= r_vec;
                  end
               end
               // The all-ones vector is the last one, so vec never wraps;
               // X is cleared as the sweep enters DONE.
               if (w_last_vec) begin
                  r_vec <= '0;
               end else begin
                  r_vec <= r_vec + N'(1);
               end
            end
            default: begin
               r_vec <= r_vec;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_majority_gate_bist.sv
// Bench for majority_gate_bist. It uses an 8-input engine and a 4-input
// engine with a 4-bit error counter. Each engine drives a behavioural gate
// that has selectable faults. A reference model predicts the sweep results.
module tb_majority_gate_bist;

   logic         clk;
   logic         rst;
   logic         start8;
   logic         start4;

   logic [7:0]   x8;
   logic         y8;
   logic         busy8;
   logic         done8;
   logic         pass8;
   logic [15:0]  err8;
   logic         fs8;
   logic [7:0]   ff8;

   logic [3:0]   x4;
   logic         y4;
   logic         busy4;
   logic         done4;
   logic         pass4;
   logic [3:0]   err4;
   logic         fs4;
   logic [3:0]   ff4;

   int           mode8;
   int           mode4;
   logic [255:0] mask8;
   logic [255:0] mask4;

   int           n_vec;
   int           n_err;

   majority_gate_bist #(.N(8), .ERR_W(16)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .X          (x8),
      .Y          (y8),
      .busy       (busy8),
      .done       (done8),
      .pass       (pass8),
      .err_count  (err8),
      .fail_seen  (fs8),
      .first_fail (ff8)
   );

   majority_gate_bist #(.N(4), .ERR_W(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .start      (start4),
      .X          (x4),
      .Y          (y4),
      .busy       (busy4),
      .done       (done4),
      .pass       (pass4),
      .err_count  (err4),
      .fail_seen  (fs4),
      .first_fail (ff4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate under test:
   //   mode 0 = correct, 1 = stuck at 0, 2 = inverted,
   //   3 = outputs 1 on ties, other values = correct XOR a per-vector fault mask.
   function automatic logic gate_model(input int x, input int n, input int mode,
                                       input logic [255:0] mask);
      int ones;
      ones = $countones(x);
      case (mode)
         0:       return (2 * ones > n);
         1:       return 1'b0;
         2:       return !(2 * ones > n);
         3:       return (2 * ones >= n);
         default: return (2 * ones > n) ^ mask[x];
      endcase
   endfunction

   always_comb y8 = gate_model(int'(x8), 8, mode8, mask8);
   always_comb y4 = gate_model(int'(x4), 4, mode4, mask4);

   // Predicts the sweep results: the error count saturates, and first_fail
   // keeps the first mismatching vector.
   task automatic ref_model(input int n, input int errw, input int mode,
                            input logic [255:0] mask,
                            output int errs, output int ff, output int fs);
      int  satmax;
      logic exp_v;
      satmax = (1 << errw) - 1;
      errs = 0;
      ff   = 0;
      fs   = 0;
      for (int v = 0; v < (1 << n); v++) begin
         exp_v = ($countones(v) * 2 > n);
         if (gate_model(v, n, mode, mask) != exp_v) begin
            if (errs < satmax) errs++;
            if (fs == 0) begin
               fs = 1;
               ff = v;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic get(input int w, output logic [31:0] ox, output logic [31:0] ob,
                      output logic [31:0] od, output logic [31:0] op,
                      output logic [31:0] oe, output logic [31:0] ofs,
                      output logic [31:0] off);
      if (w == 8) begin
         ox = 32'(x8);  ob = 32'(busy8); od = 32'(done8); op = 32'(pass8);
         oe = 32'(err8); ofs = 32'(fs8); off = 32'(ff8);
      end else begin
         ox = 32'(x4);  ob = 32'(busy4); od = 32'(done4); op = 32'(pass4);
         oe = 32'(err4); ofs = 32'(fs4); off = 32'(ff4);
      end
   endtask

   task automatic set_start(input int w, input logic v);
      if (w == 8) start8 = v;
      else        start4 = v;
   endtask

   // Start is accepted at the next rising edge; the task returns 1 time unit after it.
   task automatic pulse_start(input int w);
      @(negedge clk);
      set_start(w, 1'b1);
      @(posedge clk);
      #1;
      set_start(w, 1'b0);
   endtask

   task automatic sweep(input int w, input int mode, input bit noise);
      int n, errw, t_done, errs, ff, fs;
      logic [31:0] ox, ob, od, op, oe, ofs, off;
      n      = w;
      errw   = (w == 8) ? 16 : 4;
      t_done = (1 << n) * (n + 2);
      if (w == 8) mode8 = mode;
      else        mode4 = mode;
      ref_model(n, errw, mode, (w == 8) ? mask8 : mask4, errs, ff, fs);
      pulse_start(w);
      get(w, ox, ob, od, op, oe, ofs, off);
      chk("accept_busy", ob, 1);
      chk("accept_err_clr", oe, 0);
      chk("accept_fs_clr", ofs, 0);
      chk("accept_ff_clr", off, 0);
      for (int k = 1; k < t_done; k++) begin
         @(posedge clk);
         #1;
         if (k % (n + 2) == n + 1) begin
            get(w, ox, ob, od, op, oe, ofs, off);
            chk("x_at_check", ox, 32'(k / (n + 2)));
            chk("busy_at_check", ob, 1);
         end
         if (noise)
            set_start(w, (k < t_done - 1) && ($urandom_range(0, 63) == 0));
      end
      set_start(w, 1'b0);
      get(w, ox, ob, od, op, oe, ofs, off);
      chk("done_early", od, 0);
      @(posedge clk);
      #1;
      get(w, ox, ob, od, op, oe, ofs, off);
      chk("done_rise", od, 1);
      chk("done_busy", ob, 0);
      chk("done_pass", op, 32'(errs == 0));
      chk("done_err", oe, 32'(errs));
      chk("done_fs", ofs, 32'(fs));
      chk("done_ff", off, 32'(ff));
      chk("done_x", ox, 0);
   endtask

   initial begin
      logic [31:0] ox, ob, od, op, oe, ofs, off;
      n_vec  = 0;
      n_err  = 0;
      rst    = 1'b1;
      start8 = 1'b0;
      start4 = 1'b0;
      mode8  = 0;
      mode4  = 0;
      mask8  = '0;
      mask4  = '0;

      repeat (3) @(posedge clk);
      #1;
      for (int w = 4; w <= 8; w += 4) begin
         get(w, ox, ob, od, op, oe, ofs, off);
         chk("rst_x", ox, 0);
         chk("rst_busy", ob, 0);
         chk("rst_done", od, 0);
         chk("rst_pass", op, 0);
         chk("rst_err", oe, 0);
         chk("rst_fs", ofs, 0);
         chk("rst_ff", off, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Correct 8-input gate; random start pulses while busy must be ignored.
      sweep(8, 0, 1'b1);

      // Faulty 4-input gates: stuck-at-0, inverted (counter saturates),
      // ties read as 1; then restart with a correct gate.
      sweep(4, 1, 1'b0);
      sweep(4, 2, 1'b1);
      sweep(4, 3, 1'b0);
      sweep(4, 0, 1'b0);

      // Random per-vector fault masks.
      for (int r = 0; r < 3; r++) begin
         mask4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         sweep(4, 4, 1'b1);
      end
      mask8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sweep(8, 4, 1'b0);

      // Reset mid-sweep with errors accumulated: outputs clear at once.
      mode8 = 2;
      pulse_start(8);
      repeat (99) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      get(8, ox, ob, od, op, oe, ofs, off);
      chk("midrst_x", ox, 0);
      chk("midrst_busy", ob, 0);
      chk("midrst_done", od, 0);
      chk("midrst_pass", op, 0);
      chk("midrst_err", oe, 0);
      chk("midrst_fs", ofs, 0);
      chk("midrst_ff", off, 0);

      // When rst and start are both high, rst wins.
      @(negedge clk);
      start8 = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_start_busy", 32'(busy8), 0);
      @(negedge clk);
      rst    = 1'b0;
      start8 = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_rst", 32'(busy8), 0);

      sweep(8, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/majority_gate_bist.md
Name: majority_gate_bist

Overview:
Built-in self-test engine for the N-input majority gate. It sweeps every N-bit vector onto the gate input and computes the expected majority serially with an internal popcount. It samples the gate output, compares it against the expected value, and reports the error count, the first failing vector and a pass/fail verdict. It sits at the driving end of the gate interface and replaces the open-loop stimulus with a self-checking hardware sweep.

Parameters:
N, 8, width of the gate input bus (N >= 2)
ERR_W, 16, width of the saturating error counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
X  out  N  vector driven onto the gate input
Y  in  1  gate output under test
busy  out  1  high while a sweep is in progress
done  out  1  high in DONE until the next start
pass  out  1  valid when done=1; 1 iff err_count==0
err_count  out  ERR_W  number of mismatching vectors, saturating
fail_seen  out  1  at least one mismatch seen this sweep
first_fail  out  N  first mismatching vector; 0 if none

Behaviour:
- Reset (async, rst=1): state=IDLE, X=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, first_fail=0, internal counters=0. Applies immediately, including mid-sweep.
- X is a register (vec). It changes only on entry to APPLY for the next vector and is cleared on entry to DONE.
- Expected majority: exp = 1 iff 2*ones > N.
  - Even-N ties give exp=0.
  - ones is clog2(N+1) bits wide.
- FSM:
  - IDLE: busy=0. start=1 -> APPLY; vec=0; err_count, fail_seen, first_fail, pass, done cleared.
  - APPLY (1 cycle): sh<=vec, ones<=0, bitcnt<=0 -> COUNT.
  - COUNT (exactly N cycles): ones<=ones+sh[0], sh<=sh>>1, bitcnt++. When the Nth bit is consumed -> CHECK.
  - CHECK (1 cycle): Y is sampled here; X has been stable for N+1 cycles.
    - If Y!=exp: err_count<=err_count+1, saturating at 2^ERR_W-1.
    - On the first mismatch: first_fail<=vec, fail_seen<=1.
    - If vec==2^N-1 -> DONE; otherwise vec<=vec+1 -> APPLY.
  - DONE: done=1, busy=0, pass=(err_count==0), X=0. Results hold. start=1 restarts exactly as from IDLE: results cleared, -> APPLY.
- busy=1 in APPLY, COUNT and CHECK. start is ignored while busy.
- Timing:
  - Each vector takes N+2 cycles.
  - Take the edge that accepts start as edge 0. done rises after edge 2^N*(N+2): 2560 cycles for N=8, 40 for N=3.
- Vector counter wrap: vec never wraps. The terminal test is vec==2^N-1 (all ones), so the sweep covers 0..2^N-1 exactly once.
- Error-count saturation does not stop the sweep; fail_seen and first_fail are unaffected by saturation.
- Simultaneous rst and start: rst wins.

Test Plan:
- N=8, correct combinational majority gate on X/Y, pulse start -> busy for 2560 cycles; then done=1, pass=1, err_count=0, fail_seen=0, first_fail=0, X=0.
- N=3, Y tied 0 -> exp=1 for vectors 3,5,6,7; done at cycle 40 with err_count=4, first_fail=3'b011, fail_seen=1, pass=0.
- N=3, Y = inverted correct majority -> err_count=8, first_fail=0, pass=0. Repeat with ERR_W=2 -> err_count saturates at 3, fail_seen=1, done still at cycle 40.
- N=4, gate wrongly outputs 1 on ties (2*ones>=N) -> err_count=6 (the C(4,2) tie vectors), first_fail=4'b0011.
- N=8, correct gate:
  - Pulse start again at cycles 5 and 500 -> ignored, done still at 2560.
  - Assert rst at cycle 100 -> all outputs 0 immediately.
  - Release rst and pulse start -> clean sweep, pass=1 at 2560 cycles after start.
- After DONE with failures, pulse start with a correct gate -> err_count, fail_seen and first_fail cleared on acceptance; new sweep ends pass=1.
